// File: rtl/sdram_wr_buffer.sv
// User-side write buffer: show-ahead FIFO that stores 16-bit words and presents them
// to the SDRAM write controller one full burst (page) at a time.
module sdram_wr_buffer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = 256
) (
  input  logic                     sysclk_100M,
  input  logic                     rst,
  input  logic                     usr_wr_en,
  input  logic [DATA_W-1:0]        usr_wr_data,
  output logic                     usr_full,
  output logic                     usr_overflow,
  output logic                     write_trig,
  input  logic                     write_data_vld,
  output logic [DATA_W-1:0]        w_dq,
  output logic                     burst_done,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_LVL_C = CW'(BURST_LEN);
  localparam logic [BW-1:0] BURST_END_C = BW'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIG  = 2'd1,
    BURST = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              full_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  state_t            state_r;
  logic [BW-1:0]     burst_cnt_r;
  logic              write_trig_r;
  logic              burst_done_r;

  // Accept/drop decisions and next occupancy; a pop on a full FIFO makes room for a same-cycle push.
  always_comb begin
    pop_ok_s     = 1'b0;
    push_ok_s    = 1'b0;
    count_next_s = count_r;
    if (write_data_vld && (count_r != {CW{1'b0}})) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (usr_wr_en && ((count_r != DEPTH_C) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; intentionally not reset, contents are don't-care until written.
  always_ff @(posedge sysclk_100M) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= usr_wr_data;
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r     <= count_next_s;
      full_r      <= (count_next_s == DEPTH_C);
      overflow_r  <= usr_wr_en & ~push_ok_s;
      underflow_r <= underflow_r | (write_data_vld & (count_r == {CW{1'b0}}));
    end
  end

  // Burst sequencer: arm the trigger once a page is stored, then count one page of pops.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      burst_cnt_r  <= {BW{1'b0}};
      write_trig_r <= 1'b0;
      burst_done_r <= 1'b0;
    end else begin
      burst_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (count_r >= BURST_LVL_C) begin
            state_r      <= TRIG;
            write_trig_r <= 1'b1;
          end else begin
            write_trig_r <= 1'b0;
          end
        end
        TRIG: begin
          if (pop_ok_s) begin
            state_r      <= BURST;
            burst_cnt_r  <= BW'(1);
            write_trig_r <= 1'b0;
          end else begin
            write_trig_r <= 1'b1;
          end
        end
        BURST: begin
          write_trig_r <= 1'b0;
          if (pop_ok_s) begin
            if ((burst_cnt_r + BW'(1)) == BURST_END_C) begin
              burst_done_r <= 1'b1;
              burst_cnt_r  <= {BW{1'b0}};
              state_r      <= IDLE;
            end else begin
              burst_cnt_r <= burst_cnt_r + BW'(1);
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          burst_cnt_r  <= {BW{1'b0}};
          write_trig_r <= 1'b0;
        end
      endcase
    end
  end

  assign w_dq         = mem_r[rd_ptr_r];
  assign usr_full     = full_r;
  assign usr_overflow = overflow_r;
  assign underflow    = underflow_r;
  assign fill_level   = count_r;
  assign write_trig   = write_trig_r;
  assign burst_done   = burst_done_r;

endmodule

// File: doc/sdram_wr_buffer.md
# sdram_wr_buffer

User-side write buffer feeding the SDRAM write path. It accepts 16-bit words from the user domain into a synchronous show-ahead FIFO and raises `write_trig` once a full burst is stored. It then hands words to the SDRAM write controller, one per `write_data_vld` strobe, through `w_dq`. It sits directly upstream of the arbiter's write port and shares its clock.

## Interface
- `DATA_W`, 16, word width; must match SDRAM `dq`.
- `DEPTH`, 512, FIFO depth in words; power of two, ≥ 2×`BURST_LEN`.
- `BURST_LEN`, 256, words per write burst (one full page).
- `sysclk_100M`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `usr_wr_en`  in  1  push strobe.
- `usr_wr_data`  in  `DATA_W`  push data.
- `usr_full`  out  1  FIFO full; a push is dropped while high.
- `usr_overflow`  out  1  one-cycle pulse on a dropped push.
- `write_trig`  out  1  a burst is ready; to the SDRAM write controller.
- `write_data_vld`  in  1  pop strobe from the write controller.
- `w_dq`  out  `DATA_W`  head-of-FIFO word (show-ahead).
- `burst_done`  out  1  one-cycle pulse when the `BURST_LEN`-th pop of a burst occurs.
- `underflow`  out  1  sticky; set by a pop while empty, cleared only by `rst`.
- `fill_level`  out  log2(`DEPTH`)+1  current word count.

## Operation
- **Storage:** `DEPTH`-entry array. Write and read pointers are log2(`DEPTH`) bits and wrap naturally modulo `DEPTH`. A separate count register of log2(`DEPTH`)+1 bits drives `fill_level`.
- **Push:** accepted when `usr_wr_en` is high and count < `DEPTH`. The word is written at the write pointer, which then advances.
- **Dropped push:** a push with count == `DEPTH` is dropped and `usr_overflow` pulses on the next cycle.
- **Pop:** accepted when `write_data_vld` is high and count > 0. The word on `w_dq` that cycle is consumed and the read pointer advances.
- **Empty pop:** a pop with count == 0 has no pointer or count change and sets `underflow`.
- **Simultaneous push and pop:** both accepted, count unchanged. When full, the pop frees space in the same cycle, so the push is accepted. When empty, the pop is an underflow and only the push takes effect.
- **`w_dq`:** always reads the array at the read pointer combinationally. Its value is undefined (don't-care) while empty.
- **`usr_full`:** equals (count == `DEPTH`), driven from registered count.
- **Burst FSM**, states `IDLE`, `TRIG`, `BURST`:
  - `IDLE`: `write_trig` = 0. Go to `TRIG` when count ≥ `BURST_LEN`.
  - `TRIG`: `write_trig` = 1. On the first accepted pop, set `burst_cnt` = 1, drop `write_trig` and go to `BURST`.
  - `BURST`: `write_trig` = 0. Each accepted pop increments `burst_cnt`. When the pop taking `burst_cnt` to `BURST_LEN` is accepted, pulse `burst_done`, clear `burst_cnt` and return to `IDLE`.
- **Burst counter:** `burst_cnt` is log2(`BURST_LEN`)+1 bits.
- **Pops outside a burst:** pops in `IDLE` are honoured as FIFO pops but not counted toward a burst.
- **Reset** (asynchronous, any time, including mid-burst):
  - Pointers, count and `burst_cnt` go to 0; FSM goes to `IDLE`.
  - `write_trig`, `usr_full`, `usr_overflow`, `burst_done` and `underflow` go to 0; `fill_level` goes to 0.
  - Stored data is discarded. Array contents are not reset.

## Timing
- Push at edge N: `fill_level` updates after edge N.
  - If the FIFO was empty, `w_dq` shows the word from after edge N.
  - If count reaches `BURST_LEN`, the FSM enters `TRIG` at edge N+1 and `write_trig` is high from edge N+1.
- **Trigger latency:** push of word `BURST_LEN` to `write_trig` high is 1 cycle.
- **`write_trig` hold:** stays high until the first pop is accepted, then is low from the following cycle.
- **Back-to-back pops:** one word per cycle. `w_dq` shows the next word the cycle after each pop.
- **`burst_done` and re-trigger:** `burst_done` is high the cycle after the final pop of a burst. `write_trig` may re-assert no earlier than 1 cycle after `burst_done`, and only if count ≥ `BURST_LEN`.
- **Flag alignment:** `usr_overflow` and `burst_done` are registered pulses, each exactly 1 cycle wide.
- No combinational path from `write_data_vld` to `write_trig`.

## Test plan
- **Fill to trigger:** reset, then push 0x0000..0x00FF on consecutive cycles → `write_trig` rises 1 cycle after the 256th push; `fill_level` = 256; `w_dq` = 0x0000.
- **Full burst drain:** from the previous state, strobe `write_data_vld` for 256 cycles → `w_dq` sequence 0x0000..0x00FF. `write_trig` is low after the first pop; `burst_done` pulses once; `fill_level` = 0; FSM is back in `IDLE`.
- **Fill and overflow:** push 513 words with no pops → `usr_full` high after word 512; the 513th is dropped with one `usr_overflow` pulse; `fill_level` = 512.
- **Simultaneous events and wrap:**
  - At count 512, push + pop in the same cycle → push accepted, no overflow, `fill_level` stays 512.
  - Run 3 full bursts (768 words) → pointer wrap with data intact.
- **Underflow:** pop with `fill_level` = 0 → `underflow` set and held, `fill_level` stays 0; a later `rst` clears it.
- **Reset mid-burst:** assert `rst` after 100 of 256 pops → all outputs 0 immediately. A fresh fill of 256 words gives a correct new burst starting from the first word pushed after reset.
